axis_usb_packetiser: RTL
========================

// Module: axis_usb_packetiser
// PURPOSE
//   Single-clock AXI-Stream frame-to-USB-packet segmenter on the bulk IN path.
//   It reads byte frames drained from the block FIFO and re-emits them as USB
//   packets of at most MAX_PKT bytes, asserting m_tlast at each packet end.
//   When ENABLE_ZLP is set and a frame ends exactly on a MAX_PKT boundary, it
//   appends a zero-length-packet (ZLP) marker beat, so the host sees transfer end.
// PARAMETERS
//   MAX_PKT     512  max bytes per USB packet; 1..1024; sets wMaxPacketSize
//   CBITS       10   packet byte-counter width; must satisfy 2**CBITS >= MAX_PKT
//   ENABLE_ZLP  1    1: emit a ZLP marker after frames of length k*MAX_PKT; 0: never
// PORTS
//   clock      in   1  system clock; all logic is rising-edge
//   reset_n    in   1  asynchronous, active-low reset
//   s_tvalid   in   1  input frame beat valid
//   s_tready   out  1  input beat accepted when s_tvalid && s_tready
//   s_tlast    in   1  last byte of input frame
//   s_tdata    in   8  input byte
//   m_tvalid   out  1  output beat valid (registered)
//   m_tready   in   1  downstream ready
//   m_tkeep    out  1  1: data byte; 0: ZLP marker (no payload)
//   m_tlast    out  1  last beat of a USB packet
//   m_tdata    out  8  output byte; 0x00 on ZLP marker beats
//   frame_done out  1  1-cycle pulse when the final beat of a frame transfers on m_*
// BEHAVIOUR
//   Clock and reset: one clock domain. Reset is asynchronous and active-low.
//   - Async reset (reset_n=0) clears outputs immediately:
//     m_tvalid=0, m_tkeep=0, m_tlast=0, m_tdata=0x00, frame_done=0.
//     It also clears the internal state: state=ST_DATA, count=0.
//   - Output register: one stage. An accepted s_* beat appears on m_* on the next
//     clock. Throughput is 1 beat/cycle when m_tready is held at 1.
//   - s_tready = (state==ST_DATA) && (!m_tvalid || m_tready). This is combinational
//     from m_tready. It is 1 out of reset.
//   - m_tvalid, m_tkeep, m_tlast and m_tdata are held stable while m_tvalid && !m_tready.
//   - count[CBITS-1:0] = bytes already emitted in the current packet.
//   States:
//   - ST_DATA: on s_tvalid && s_tready:
//       load m_tdata=s_tdata, m_tkeep=1, m_tvalid=1;
//       set brk = s_tlast || (count==MAX_PKT-1); m_tlast=brk;
//       if brk then count<=0, else count<=count+1;
//       if s_tlast && count==MAX_PKT-1 && ENABLE_ZLP, go to ST_ZLP.
//     With no accept: if m_tvalid && m_tready, then m_tvalid<=0.
//   - ST_ZLP: s_tready=0. The pending full-packet last beat drains first.
//     The first cycle with (!m_tvalid || m_tready) loads the marker:
//     m_tvalid=1, m_tkeep=0, m_tlast=1, m_tdata=0.
//     When the marker transfers, return to ST_DATA.
//   - frame_done pulses on the cycle after the m_* handshake of the frame's final beat.
//     Without a ZLP, that beat is the s_tlast byte. With a ZLP, it is the ZLP marker.
//     Each frame gives exactly one pulse.
//   Boundaries:
//   - A frame shorter than MAX_PKT, or of length k*MAX_PKT+r with r>0, ends with a
//     short packet and gets no ZLP.
//   - MAX_PKT==1: every byte has m_tlast=1. With ENABLE_ZLP, every frame ends with a
//     ZLP marker.
//   - A 1-byte frame is a valid short packet.
//   - Frame length is unbounded; count wraps to 0 at each packet boundary only.
//   - Reset mid-frame or mid-ZLP discards the partial output; the next accepted byte
//     starts a new packet with count=0.
// TESTING
//   T1 MAX_PKT=8, m_tready=1, frame 0x01..0x05 -> 5 consecutive beats,
//      first beat 1 cycle after accept, m_tlast only on 0x05, no ZLP,
//      one frame_done pulse.
//   T2 MAX_PKT=8, 20-byte frame 0x00..0x13 -> m_tlast on 0x07, 0x0F and 0x13;
//      packet sizes 8,8,4; all m_tkeep=1.
//   T3 MAX_PKT=8, ENABLE_ZLP=1, 16-byte frame -> m_tlast on 0x07 and 0x0F, then
//      one beat with m_tkeep=0, m_tlast=1, m_tdata=0; s_tready=0 until it transfers.
//      Rerun with ENABLE_ZLP=0 -> no marker beat.
//   T4 MAX_PKT=8, 3 frames of 1/8/13 bytes; random m_tready (50%) and s_tvalid
//      gaps -> byte order preserved; m_* stable while stalled; exactly 3
//      frame_done pulses; exactly 1 ZLP (after the 8-byte frame).
//   T5 Assert reset_n=0 after 5 bytes of a MAX_PKT=8 frame -> all outputs 0 in the
//      same cycle. After release, a new 8-byte frame gives m_tlast on its 8th byte.
//   T6 MAX_PKT=1, ENABLE_ZLP=1, back-to-back 1-byte frames 0xA5 then 0x5A ->
//      beats A5(last), ZLP, 5A(last), ZLP.

Source files
------------

// File: rtl/axis_usb_packetiser.sv
// Splits AXI-Stream byte frames into USB packets of at most MAX_PKT bytes, with an optional ZLP marker after frames that end on a packet boundary.
// Latency: one registered output stage. Backpressure: s_tready follows m_tready combinationally and is held low while a ZLP marker is pending.
module axis_usb_packetiser #(
   parameter int MAX_PKT    = 512,
   parameter int CBITS      = 10,
   parameter int ENABLE_ZLP = 1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       s_tvalid,
   output logic       s_tready,
   input  logic       s_tlast,
   input  logic [7:0] s_tdata,
   output logic       m_tvalid,
   input  logic       m_tready,
   output logic       m_tkeep,
   output logic       m_tlast,
   output logic [7:0] m_tdata,
   output logic       frame_done
);

   typedef enum logic {ST_DATA, ST_ZLP} state_t;

   localparam logic [CBITS-1:0] LAST_CNT = CBITS'(MAX_PKT - 1);

   state_t           state, state_d;
   logic [CBITS-1:0] count, count_d;
   logic             vld_d, keep_d, last_d, done_d;
   logic [7:0]       data_d;
   // Marks that the beat held in the output register closes a frame.
   logic             eof, eof_d;
   logic             out_free, brk, pkt_full;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_DATA;
         count      <= '0;
         m_tvalid   <= 1'b0;
         m_tkeep    <= 1'b0;
         m_tlast    <= 1'b0;
         m_tdata    <= 8'h00;
         frame_done <= 1'b0;
         eof        <= 1'b0;
      end else begin
         state      <= state_d;
         count      <= count_d;
         m_tvalid   <= vld_d;
         m_tkeep    <= keep_d;
         m_tlast    <= last_d;
         m_tdata    <= data_d;
         frame_done <= done_d;
         eof        <= eof_d;
      end
   end

   always_comb begin
      state_d  = state;
      count_d  = count;
      vld_d    = m_tvalid;
      keep_d   = m_tkeep;
      last_d   = m_tlast;
      data_d   = m_tdata;
      eof_d    = eof;
      done_d   = m_tvalid && m_tready && eof;
      out_free = !m_tvalid || m_tready;
      s_tready = (state == ST_DATA) && out_free;
      pkt_full = (count == LAST_CNT);
      brk      = s_tlast || pkt_full;

      case (state)
         ST_DATA: begin
            if (s_tvalid && s_tready) begin
               vld_d   = 1'b1;
               keep_d  = 1'b1;
               last_d  = brk;
               data_d  = s_tdata;
               count_d = brk ? '0 : count + CBITS'(1);
               if (s_tlast && pkt_full && (ENABLE_ZLP != 0)) begin
                  state_d = ST_ZLP;
                  eof_d   = 1'b0;
               end else begin
                  eof_d   = s_tlast;
               end
            end else if (m_tvalid && m_tready) begin
               vld_d = 1'b0;
            end
         end
         ST_ZLP: begin
            // A valid beat with keep low can only be the marker itself.
            if (m_tvalid && !m_tkeep) begin
               if (m_tready) begin
                  vld_d   = 1'b0;
                  state_d = ST_DATA;
               end
            end else if (out_free) begin
               vld_d  = 1'b1;
               keep_d = 1'b0;
               last_d = 1'b1;
               data_d = 8'h00;
               eof_d  = 1'b1;
            end
         end
         default: state_d = ST_DATA;
      endcase
   end

endmodule
